// File: rtl/ksa_param_if.sv
// RC4 key-schedule engine bus: start handshake, key and single-port S-box RAM port.
// Latency: none, wires only.
// Backpressure: none; the controller may start only while rdy=1.
interface ksa_param_if #(
  parameter int ADDR_W  = 8,
  parameter int KEY_LEN = 3
);
  logic                        en;
  logic                        init_mode;
  logic [KEY_LEN*ADDR_W-1:0]   key;
  logic                        rdy;
  logic [ADDR_W-1:0]           addr;
  logic [ADDR_W-1:0]           rddata;
  logic [ADDR_W-1:0]           wrdata;
  logic                        wren;

  // Controller / RAM side: issues starts and returns read data.
  modport master (
    output en, init_mode, key, rddata,
    input  rdy, addr, wrdata, wren
  );

  // Key-schedule engine side.
  modport slave (
    input  en, init_mode, key, rddata,
    output rdy, addr, wrdata, wren
  );
endinterface

// File: rtl/ksa_param.sv
// RC4 key-scheduling engine: optional S[i]=i fill, then swap S[i],S[j] with j += S[i] + key sym.
// Latency: N cycles of fill (optional) plus 6 cycles per entry; rdy returns the cycle after the last write.
// Backpressure: none; en is only honoured while rdy=1, all RAM outputs are registered.
module ksa_param #(
  parameter int ADDR_W  = 8,
  parameter int KEY_LEN = 3
) (
  input  logic         clk,
  input  logic         rst,
  ksa_param_if.slave   bus
);

  localparam int                KW    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [ADDR_W-1:0] LAST  = '1;
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [KW-1:0]     KLAST = KW'(KEY_LEN - 1);
  localparam logic [KW-1:0]     KONE  = KW'(1);

  typedef enum logic [2:0] {
    IDLE, FILL, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J
  } state_t;

  state_t                    state, state_n;
  logic [ADDR_W-1:0]         i, i_n;
  logic [ADDR_W-1:0]         j, j_n;
  logic [ADDR_W-1:0]         si, si_n;
  logic [ADDR_W-1:0]         sj, sj_n;
  logic [KW-1:0]             kidx, kidx_n;
  logic [KEY_LEN*ADDR_W-1:0] key_q;
  logic [ADDR_W-1:0]         key_sym;
  logic                      start;

  logic                      rdy_q, rdy_n;
  logic                      wren_q, wren_n;
  logic [ADDR_W-1:0]         addr_q, addr_n;
  logic [ADDR_W-1:0]         wrdata_q, wrdata_n;

  assign bus.rdy    = rdy_q;
  assign bus.wren   = wren_q;
  assign bus.addr   = addr_q;
  assign bus.wrdata = wrdata_q;

  // Select the current key symbol; symbol 0 sits in the key MSBs.
  always_comb begin
    key_sym = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (int'(kidx) == k) key_sym = key_q[(KEY_LEN-1-k)*ADDR_W +: ADDR_W];
    end
  end

  // Next-state logic; outputs are decoded from the next state so they leave a flop.
  always_comb begin
    state_n  = state;
    i_n      = i;
    j_n      = j;
    si_n     = si;
    sj_n     = sj;
    kidx_n   = kidx;
    start    = 1'b0;
    rdy_n    = 1'b0;
    wren_n   = 1'b0;
    addr_n   = '0;
    wrdata_n = '0;

    case (state)
      IDLE: begin
        if (bus.en) begin
          start   = 1'b1;
          i_n     = '0;
          j_n     = '0;
          kidx_n  = '0;
          state_n = bus.init_mode ? FILL : RD_I;
        end
      end
      FILL: begin
        // i wraps back to 0 on the last fill write, ready for the schedule loop.
        i_n = i + ONE;
        if (i == LAST) state_n = RD_I;
      end
      RD_I: state_n = WT_I;
      WT_I: begin
        // S[i] arrives now; j is advanced here so RD_J can present it registered.
        si_n    = bus.rddata;
        j_n     = j + bus.rddata + key_sym;
        state_n = RD_J;
      end
      RD_J: state_n = WT_J;
      WT_J: begin
        sj_n    = bus.rddata;
        state_n = WR_I;
      end
      WR_I: state_n = WR_J;
      WR_J: begin
        i_n     = i + ONE;
        kidx_n  = (kidx == KLAST) ? '0 : kidx + KONE;
        state_n = (i == LAST) ? IDLE : RD_I;
      end
      default: state_n = IDLE;
    endcase

    case (state_n)
      IDLE: rdy_n = 1'b1;
      FILL: begin
        addr_n   = i_n;
        wrdata_n = i_n;
        wren_n   = 1'b1;
      end
      RD_I: addr_n = i_n;
      RD_J: addr_n = j_n;
      WR_I: begin
        addr_n   = i_n;
        wrdata_n = sj_n;
        wren_n   = 1'b1;
      end
      WR_J: begin
        addr_n   = j_n;
        wrdata_n = si_n;
        wren_n   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, datapath and output registers; reset aborts any run immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      si       <= '0;
      sj       <= '0;
      kidx     <= '0;
      key_q    <= '0;
      rdy_q    <= 1'b1;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      state    <= state_n;
      i        <= i_n;
      j        <= j_n;
      si       <= si_n;
      sj       <= sj_n;
      kidx     <= kidx_n;
      if (start) key_q <= bus.key;
      rdy_q    <= rdy_n;
      wren_q   <= wren_n;
      addr_q   <= addr_n;
      wrdata_q <= wrdata_n;
    end
  end

endmodule

// File: tb/tb_ksa_param.sv
// Bench for ksa_param: two instances (8-bit/3-sym and 4-bit/5-sym) each with a model RAM.
// Latency: run lengths are measured against N (+N fill) + 6N cycles.
// Backpressure: none; expected writes are queued at stimulus time and popped on every wren.
module tb_ksa_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ksa_param_if #(.ADDR_W(8), .KEY_LEN(3)) ifa ();
  ksa_param_if #(.ADDR_W(4), .KEY_LEN(5)) ifb ();

  ksa_param #(.ADDR_W(8), .KEY_LEN(3)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  ksa_param #(.ADDR_W(4), .KEY_LEN(5)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic [7:0] ram_a [256];
  logic [3:0] ram_b [16];

  // Single-port S-box RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (ifa.wren === 1'b1) ram_a[ifa.addr] <= ifa.wrdata;
    ifa.rddata <= ram_a[ifa.addr];
  end

  always @(posedge clk) begin
    if (ifb.wren === 1'b1) ram_b[ifb.addr] <= ifb.wrdata;
    ifb.rddata <= ram_b[ifb.addr];
  end

  typedef struct {
    int a;
    int d;
  } wr_t;

  wr_t q_a[$];
  wr_t q_b[$];
  int  ms [2][256];
  int  ks [2][32];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int w, input int a, input int d);
    wr_t e;
    e.a = a;
    e.d = d;
    if (w == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic model_fill(input int w, input int n);
    for (int k = 0; k < n; k++) begin
      ms[w][k] = k;
      push(w, k, k);
    end
  endtask

  // Golden key schedule; writes for i < first_push are left to the caller,
  // and abort_i stops after the S[i] write of that iteration.
  task automatic model_sched(input int w, input int n, input int klen,
                             input int first_push, input int abort_i);
    int j;
    int si;
    int sj;
    j = 0;
    for (int i = 0; i < n; i++) begin
      j  = (j + ms[w][i] + ks[w][i % klen]) % n;
      si = ms[w][i];
      sj = ms[w][j];
      if (i >= first_push) push(w, i, sj);
      ms[w][i] = sj;
      if (i == abort_i) return;
      if (i >= first_push) push(w, j, si);
      ms[w][j] = si;
    end
  endtask

  task automatic check_wr(input int w, input int a, input int d);
    wr_t   e;
    string nm;
    nm = (w == 0) ? "wr_a" : "wr_b";
    n_cmp++;
    if ((w == 0 && q_a.size() == 0) || (w == 1 && q_b.size() == 0)) begin
      n_bad++;
      $display("FAIL %s: unexpected write addr=%0h data=%0h, none expected", nm, a, d);
    end else begin
      e = (w == 0) ? q_a.pop_front() : q_b.pop_front();
      if (e.a != a || e.d != d) begin
        n_bad++;
        $display("FAIL %s: got addr=%0h data=%0h expected addr=%0h data=%0h", nm, a, d, e.a, e.d);
      end
    end
  endtask

  // Monitors: every write strobe is matched against the head of its queue.
  always @(negedge clk) if (ifa.wren === 1'b1) check_wr(0, int'(ifa.addr), int'(ifa.wrdata));
  always @(negedge clk) if (ifb.wren === 1'b1) check_wr(1, int'(ifb.addr), int'(ifb.wrdata));

  // Counts posedges until rdy is seen high; an expired budget is a failure.
  task automatic wait_idle(input int w, input int c0, input int budget, output int cyc);
    logic r;
    cyc = c0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      r = (w == 0) ? ifa.rdy : ifb.rdy;
      if (r === 1'b1) break;
      if (cyc > budget) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout_%0d: no rdy after %0d cycles", w, cyc);
        break;
      end
    end
  endtask

  task automatic start_a(input bit im);
    ifa.en = 1'b1;
    ifa.init_mode = im;
    @(posedge clk);
    #1;
    ifa.en = 1'b0;
  endtask

  task automatic start_b(input bit im);
    ifb.en = 1'b1;
    ifb.init_mode = im;
    @(posedge clk);
    #1;
    ifb.en = 1'b0;
  endtask

  initial begin
    int cyc;
    int sym;
    ifa.en = 1'b0; ifa.init_mode = 1'b0; ifa.key = '0;
    ifb.en = 1'b0; ifb.init_mode = 1'b0; ifb.key = '0;

    // Reset values, and en ignored while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy_a", ifa.rdy, 1);
    chk("rst_wren_a", ifa.wren, 0);
    chk("rst_addr_a", ifa.addr, 0);
    chk("rst_wrdata_a", ifa.wrdata, 0);
    chk("rst_rdy_b", ifb.rdy, 1);
    ifa.en = 1'b1;
    ifb.en = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_en_rdy_a", ifa.rdy, 1);
    chk("rst_en_wren_a", ifa.wren, 0);
    chk("rst_en_rdy_b", ifb.rdy, 1);
    ifa.en = 1'b0;
    ifb.en = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill plus schedule with key 00033C; first three iterations hand-computed.
    ifa.key = 24'h00033C;
    ks[0][0] = 'h00; ks[0][1] = 'h03; ks[0][2] = 'h3C;
    model_fill(0, 256);
    push(0, 'h00, 'h00); push(0, 'h00, 'h00);
    push(0, 'h01, 'h04); push(0, 'h04, 'h01);
    push(0, 'h02, 'h42); push(0, 'h42, 'h02);
    model_sched(0, 256, 3, 3, -1);
    start_a(1'b1);
    ifa.init_mode = 1'b0;
    ifa.key = 24'hFFFFFF;
    chk("start_rdy_drop_a", ifa.rdy, 0);
    repeat (256) @(posedge clk);
    #1;
    chk("rd_i_after_fill_addr", ifa.addr, 0);
    chk("rd_i_after_fill_wren", ifa.wren, 0);
    wait_idle(0, 256, 3000, cyc);
    chk("latency_fill_a", cyc, 1792);

    // Abort during WR_I at i=100, then a clean restart from i=0, j=0.
    ifa.key = 24'h00033C;
    model_sched(0, 256, 3, 0, 100);
    start_a(1'b0);
    repeat (604) @(posedge clk);
    #1;
    chk("abort_wr_i_wren", ifa.wren, 1);
    chk("abort_wr_i_addr", ifa.addr, 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_rdy", ifa.rdy, 1);
    chk("abort_wren", ifa.wren, 0);
    chk("abort_no_pending", q_a.size(), 0);
    rst = 1'b0;
    model_sched(0, 256, 3, 0, -1);
    start_a(1'b0);
    wait_idle(0, 0, 2000, cyc);
    chk("latency_restart_a", cyc, 1536);
    for (int k = 0; k < 256; k++) chk("final_s_a", ram_a[k], ms[0][k]);

    // Generic instance: random 5-symbol key over a 16-entry S-box.
    for (int k = 0; k < 5; k++) begin
      sym = int'($urandom_range(0, 15));
      ks[1][k] = sym;
      ifb.key[(4-k)*4 +: 4] = 4'(sym);
    end
    model_fill(1, 16);
    model_sched(1, 16, 5, 0, -1);
    start_b(1'b1);
    wait_idle(1, 0, 500, cyc);
    chk("latency_fill_b", cyc, 112);
    for (int k = 0; k < 16; k++) chk("final_s_b", ram_b[k], ms[1][k]);

    // en held high through a run gives exactly one run.
    model_sched(1, 16, 5, 0, -1);
    ifb.en = 1'b1;
    ifb.init_mode = 1'b0;
    @(posedge clk);
    #1;
    wait_idle(1, 0, 500, cyc);
    ifb.en = 1'b0;
    chk("held_en_len", cyc, 96);
    repeat (5) @(posedge clk);
    #1;
    chk("held_en_idle", ifb.rdy, 1);
    chk("held_en_no_extra", q_b.size(), 0);

    // en pulse while busy is ignored.
    model_sched(1, 16, 5, 0, -1);
    start_b(1'b0);
    repeat (20) @(posedge clk);
    #1;
    ifb.en = 1'b1;
    @(posedge clk);
    #1;
    ifb.en = 1'b0;
    wait_idle(1, 21, 500, cyc);
    chk("busy_pulse_len", cyc, 96);

    // en on the rdy cycle starts a back-to-back run.
    model_sched(1, 16, 5, 0, -1);
    model_sched(1, 16, 5, 0, -1);
    start_b(1'b0);
    wait_idle(1, 0, 500, cyc);
    chk("b2b_first_len", cyc, 96);
    start_b(1'b0);
    chk("b2b_started", ifb.rdy, 0);
    wait_idle(1, 0, 500, cyc);
    chk("b2b_second_len", cyc, 96);
    for (int k = 0; k < 16; k++) chk("final_s_b2", ram_b[k], ms[1][k]);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
